optical_manchester_tx: RTL and testbench

//  Line encoder for the optical link. Takes bytes from the UART receive path

---
 rtl/optical_manchester_tx_if.sv | 9 +
 rtl/optical_manchester_tx.sv | 128 ++++++++++++
 tb/tb_optical_manchester_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/optical_manchester_tx_if.sv
// Byte handshake between the UART receive path and the optical line encoder.
interface optical_manchester_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/optical_manchester_tx.sv
// Manchester line encoder for the optical link: one byte per frame of
// preamble, SFD, 8 data bits (LSB first) and even parity, then a quiet guard.
//
// state    | meaning
// IDLE     | q=0, ready for a byte
// PREAMBLE | alternating 1,0,... bits
// SFD      | two 1 bits
// DATA     | latched byte, LSB first
// PARITY   | XOR of the data bits
// GUARD    | q=0 for GUARD_BITS bit periods
module optical_manchester_tx #(
    parameter int CLKS_PER_HALF = 434,
    parameter int PREAMBLE_BITS = 8,
    parameter int GUARD_BITS    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    optical_manchester_tx_if.slave     tx,
    output logic                       q,
    output logic                       busy,
    output logic                       frame_done
);
    localparam int CW   = (CLKS_PER_HALF > 1) ? $clog2(CLKS_PER_HALF) : 1;
    localparam int BMAX = (PREAMBLE_BITS > 8)
                          ? ((PREAMBLE_BITS > GUARD_BITS) ? PREAMBLE_BITS : GUARD_BITS)
                          : ((GUARD_BITS > 8) ? GUARD_BITS : 8);
    localparam int BW   = $clog2(BMAX);

    localparam logic [CW-1:0] CHIP_LAST  = CW'(CLKS_PER_HALF - 1);
    localparam logic [BW-1:0] PRE_LAST   = BW'(PREAMBLE_BITS - 1);
    localparam logic [BW-1:0] SFD_LAST   = BW'(1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(7);
    localparam logic [BW-1:0] GUARD_LAST = BW'((GUARD_BITS > 0) ? GUARD_BITS - 1 : 0);

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PARITY, GUARD} state_t;

    state_t        state, state_n, follow;
    logic [CW-1:0] chip_cnt, chip_n;
    logic          half, half_n;
    logic [BW-1:0] bit_cnt, bit_n, bit_last;
    logic [7:0]    data_reg, data_n;
    logic          parity, par_n;
    logic          chip_tc, bit_v, q_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            chip_cnt <= '0;
            half     <= 1'b0;
            bit_cnt  <= '0;
            data_reg <= '0;
            parity   <= 1'b0;
            q        <= 1'b0;
        end else begin
            state    <= state_n;
            chip_cnt <= chip_n;
            half     <= half_n;
            bit_cnt  <= bit_n;
            data_reg <= data_n;
            parity   <= par_n;
            q        <= q_d;
        end
    end

    always_comb begin
        state_n  = state;
        chip_n   = chip_cnt;
        half_n   = half;
        bit_n    = bit_cnt;
        data_n   = data_reg;
        par_n    = parity;
        bit_last = '0;
        follow   = IDLE;
        bit_v    = 1'b0;
        q_d      = 1'b0;
        chip_tc  = (chip_cnt == CHIP_LAST);

        case (state)
            PREAMBLE: begin bit_last = PRE_LAST;   follow = SFD;    end
            SFD:      begin bit_last = SFD_LAST;   follow = DATA;   end
            DATA:     begin bit_last = DATA_LAST;  follow = PARITY; end
            PARITY:   begin bit_last = '0;         follow = (GUARD_BITS > 0) ? GUARD : IDLE; end
            GUARD:    begin bit_last = GUARD_LAST; follow = IDLE;   end
            default:  begin bit_last = '0;         follow = IDLE;   end
        endcase

        if (state == IDLE) begin
            if (tx.tx_valid) begin
                state_n = PREAMBLE;
                chip_n  = '0;
                half_n  = 1'b0;
                bit_n   = '0;
                data_n  = tx.tx_data;
                par_n   = ^tx.tx_data;
            end
        end else begin
            if (chip_tc) begin
                chip_n = '0;
                half_n = ~half;
            end else begin
                chip_n = chip_cnt + CW'(1);
            end
            if (chip_tc && half) begin
                if (bit_cnt == bit_last) begin
                    bit_n   = '0;
                    state_n = follow;
                end else begin
                    bit_n = bit_cnt + BW'(1);
                end
            end
        end

        // q is registered, so it is derived from the values the counters take next
        case (state_n)
            PREAMBLE: bit_v = ~bit_n[0];
            SFD:      bit_v = 1'b1;
            DATA:     bit_v = data_n[bit_n[2:0]];
            PARITY:   bit_v = par_n;
            default:  bit_v = 1'b0;
        endcase
        if (state_n inside {PREAMBLE, SFD, DATA, PARITY})
            q_d = ~(bit_v ^ half_n);
    end

    assign tx.tx_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign frame_done  = (state == PARITY) && half && chip_tc;
endmodule

// File: tb/tb_optical_manchester_tx.sv
// Scoreboard bench for optical_manchester_tx in the fast configuration.
module tb_optical_manchester_tx;
    localparam int CH  = 4;
    localparam int PRE = 8;
    localparam int GB  = 2;
    localparam int F   = (PRE + 11) * 2 * CH;
    localparam int G   = GB * 2 * CH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic q, busy, frame_done;

    optical_manchester_tx_if bus ();

    optical_manchester_tx #(
        .CLKS_PER_HALF(CH),
        .PREAMBLE_BITS(PRE),
        .GUARD_BITS   (GB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx        (bus.slave),
        .q         (q),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         k      = 0;
    logic [7:0] cur    = 8'h00;
    bit         done   = 1'b0;
    logic [3:0] exp_v, act_v;

    // Expected line level k cycles after the accept edge (1 <= k <= F).
    function automatic logic exp_chip(input logic [7:0] b, input int kk);
        int   idx;
        int   h;
        logic bv;
        idx = (kk - 1) / (2 * CH);
        h   = ((kk - 1) / CH) % 2;
        if (idx < PRE)           bv = ((idx % 2) == 0);
        else if (idx < PRE + 2)  bv = 1'b1;
        else if (idx < PRE + 10) bv = b[idx - PRE - 2];
        else                     bv = ^b;
        return (h == 1) ? bv : ~bv;
    endfunction

    // Monitor: compare {q,busy,frame_done,tx_ready} every cycle, then advance the model.
    always @(negedge clk) begin
        if (k == 0)      exp_v = 4'b0001;
        else if (k <= F) exp_v = {exp_chip(cur, k), 1'b1, (k == F), 1'b0};
        else             exp_v = 4'b0100;
        act_v = {q, busy, frame_done, bus.tx_ready};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL out k=%0d byte=%h {q,busy,done,ready}: got %b expected %b",
                     k, cur, act_v, exp_v);
        end

        if (rst) begin
            k = 0;
        end else if (k == 0) begin
            if (bus.tx_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL accept: transfer with no byte queued, got data %h", bus.tx_data);
                    cur = bus.tx_data;
                end else begin
                    cur = exp_q.pop_front();
                end
                k = 1;
            end
        end else if (k == F + G) begin
            k = 0;
        end else begin
            k++;
        end

        if (done && k == 0 && !bus.tx_valid) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL leftover: %0d bytes never sent, expected 0", exp_q.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic wait_accept();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.tx_ready && !rst) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        $display("FAIL timeout: tx_ready never high, expected within 1000 cycles");
        $fatal(1);
    endtask

    task automatic send(input logic [7:0] b, input bit release_valid);
        exp_q.push_back(b);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        wait_accept();
        if (release_valid) bus.tx_valid = 1'b0;
    endtask

    initial begin
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        rst          = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        send(8'hB2, 1'b1);
        repeat (F + G + 4) @(posedge clk);
        #1;

        send(8'hAA, 1'b0);
        send(8'h55, 1'b1);
        repeat (F + G + 2) @(posedge clk);
        #1;

        send(8'hFF, 1'b1);
        repeat (106) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h0F, 1'b1);
        repeat (F + G + 1) @(posedge clk);
        #1;

        send(8'h01, 1'b1);
        @(posedge clk);
        #1;
        bus.tx_data = 8'hFE;
        repeat (F + G + 3) @(posedge clk);
        #1;

        for (int n = 0; n < 6; n++) begin
            send(8'($urandom_range(0, 255)), 1'b1);
            bus.tx_data = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
        end

        done = 1'b1;
        repeat (2000) @(posedge clk);
        $display("FAIL watchdog: model never returned to idle, expected finish");
        $fatal(1);
    end
endmodule
